// File: rtl/clause_unpacker_if.sv
// Source-read and frame-output signals of clause_unpacker. The master modport is the unpacker;
// the slave modport is the FIFO source / frame consumer side.
interface clause_unpacker_if #(
  parameter int unsigned CLAUSE_COUNT = 20,
  parameter int unsigned CLAUSE_WIDTH = 9
);
  localparam int unsigned CntW = $clog2(CLAUSE_COUNT + 1);

  logic                             empty_i;
  logic [CLAUSE_WIDTH-1:0]          clause_i;
  logic                             rden_o;
  logic                             flush_i;
  logic [CLAUSE_WIDTH*CLAUSE_COUNT-1:0] clauses_o;
  logic [CLAUSE_COUNT-1:0]          clause_valid_o;
  logic                             frame_valid_o;
  logic                             frame_ready_i;
  logic [CntW-1:0]                  count_o;

  modport master (
    input  empty_i, clause_i, flush_i, frame_ready_i,
    output rden_o, clauses_o, clause_valid_o, frame_valid_o, count_o
  );

  modport slave (
    output empty_i, clause_i, flush_i, frame_ready_i,
    input  rden_o, clauses_o, clause_valid_o, frame_valid_o, count_o
  );
endinterface

// File: rtl/clause_unpacker.sv
// Drains a clause FIFO one clause per cycle and packs the clauses into a CLAUSE_COUNT-slot frame.
// Optional idle auto-flush is enabled by defining CLAUSE_UNPACKER_TIMEOUT_EN.
module clause_unpacker #(
  parameter int unsigned CLAUSE_COUNT = 20,
  parameter int unsigned CLAUSE_WIDTH = 9,
  parameter int unsigned TIMEOUT      = 8
) (
  input logic                clk,
  input logic                reset,
  clause_unpacker_if.master  bus
);

  localparam int unsigned CntW = $clog2(CLAUSE_COUNT + 1);
  localparam int unsigned IdxW = (CLAUSE_COUNT > 1) ? $clog2(CLAUSE_COUNT) : 1;

  typedef enum logic [0:0] {StFill, StHold} state_e;

  state_e                                state_q, state_d;
  logic [CntW-1:0]                       wp_q, wp_d;
  logic                                  rd_pend_q, rd_pend_d;
  logic                                  flush_pend_q, flush_pend_d;
  logic [CLAUSE_COUNT-1:0]               mask_q, mask_d;
  logic [CLAUSE_WIDTH*CLAUSE_COUNT-1:0]  data_q, data_d;
  logic                                  rden;
  logic                                  idle_fire;
  logic [IdxW-1:0]                       wr_idx;

  // Slots already claimed include the read still in flight.
  assign rden = (state_q == StFill) && !reset && !bus.empty_i && !flush_pend_q &&
                (({1'b0, wp_q} + (CntW + 1)'(rd_pend_q)) < (CntW + 1)'(CLAUSE_COUNT));

  assign wr_idx = IdxW'(wp_q);

`ifdef CLAUSE_UNPACKER_TIMEOUT_EN
  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

  logic [IdleW-1:0] idle_q, idle_d;

  always_comb begin
    idle_d    = '0;
    idle_fire = 1'b0;
    if (state_q == StFill && wp_q != '0 && !rden && !rd_pend_q) begin
      if (idle_q >= IdleW'(TIMEOUT - 1)) begin
        idle_fire = 1'b1;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  assign idle_fire = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    wp_d         = wp_q;
    rd_pend_d    = rden;
    flush_pend_d = flush_pend_q;
    mask_d       = mask_q;
    data_d       = data_q;
    unique case (state_q)
      StFill: begin
        if (rd_pend_q) begin
          data_d[CLAUSE_WIDTH*wr_idx +: CLAUSE_WIDTH] = bus.clause_i;
          mask_d[wr_idx]                              = 1'b1;
          wp_d                                        = wp_q + 1'b1;
        end
        // A flush with nothing captured or in flight is dropped: no empty frames.
        if ((bus.flush_i && (wp_q != '0 || rd_pend_q)) || idle_fire) begin
          flush_pend_d = 1'b1;
        end
        if (rd_pend_q && wp_q == CntW'(CLAUSE_COUNT - 1)) begin
          state_d = StHold;
        end else if (flush_pend_q && !rd_pend_q && wp_q != '0) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (bus.frame_ready_i) begin
          state_d      = StFill;
          wp_d         = '0;
          flush_pend_d = 1'b0;
          mask_d       = '0;
          data_d       = '0;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StFill;
      wp_q         <= '0;
      rd_pend_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      mask_q       <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      wp_q         <= wp_d;
      rd_pend_q    <= rd_pend_d;
      flush_pend_q <= flush_pend_d;
      mask_q       <= mask_d;
      data_q       <= data_d;
    end
  end

  assign bus.rden_o         = rden;
  assign bus.frame_valid_o  = (state_q == StHold);
  assign bus.clauses_o      = data_q;
  assign bus.clause_valid_o = mask_q;
  assign bus.count_o        = wp_q;

endmodule

// File: tb/tb_clause_unpacker.sv
// Scoreboard bench for clause_unpacker: stimulus queues expected frames, a monitor checks each
// accepted frame. Timeout expectations follow CLAUSE_UNPACKER_TIMEOUT_EN.
module tb_clause_unpacker;

  localparam int unsigned CC = 20;
  localparam int unsigned CW = 9;

  logic clk;
  logic reset;

  clause_unpacker_if #(.CLAUSE_COUNT(CC), .CLAUSE_WIDTH(CW)) bus ();

  clause_unpacker #(
    .CLAUSE_COUNT(CC),
    .CLAUSE_WIDTH(CW),
    .TIMEOUT     (8)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [CW-1:0]    src_q[$];
  logic [CW*CC-1:0] exp_data_q[$];
  logic [CC-1:0]    exp_mask_q[$];
  int               exp_cnt_q[$];

  logic [CW*CC-1:0] cur_data, last_data;
  logic [CC-1:0]    cur_mask, last_mask;
  int               cur_n;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic add_clause(input logic [CW-1:0] v);
    src_q.push_back(v);
    cur_data[CW*cur_n +: CW] = v;
    cur_mask[cur_n]          = 1'b1;
    cur_n++;
  endtask

  task automatic commit_frame();
    exp_data_q.push_back(cur_data);
    exp_mask_q.push_back(cur_mask);
    exp_cnt_q.push_back(cur_n);
    last_data = cur_data;
    last_mask = cur_mask;
    cur_data  = '0;
    cur_mask  = '0;
    cur_n     = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Source FIFO model: data appears one cycle after the read strobe.
  logic src_rd, src_rst;
  always @(posedge clk) begin
    src_rd  = bus.rden_o;
    src_rst = reset;
    #1;
    if (src_rd && !src_rst) begin
      if (src_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL src_underflow: got read strobe, required no read");
      end else begin
        bus.clause_i = src_q.pop_front();
      end
    end
  end

  // Monitor: every accepted frame is compared with the oldest expected frame.
  always @(negedge clk) begin
    if (!reset && bus.frame_valid_o && bus.frame_ready_i) begin
      if (exp_data_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got mask %0h, required no frame", bus.clause_valid_o);
      end else begin
        check("frame_data", bus.clauses_o, exp_data_q.pop_front());
        check("frame_mask", bus.clause_valid_o, exp_mask_q.pop_front());
        check("frame_count", bus.count_o, exp_cnt_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rcount;
    int fv_cyc;
    int reads;
    bit seen;
    bit flushed;

    cur_data = '0;
    cur_mask = '0;
    cur_n    = 0;
    reset             = 1'b1;
    bus.empty_i       = 1'b0;
    bus.flush_i       = 1'b0;
    bus.frame_ready_i = 1'b0;
    bus.clause_i      = '0;

    // Reset
    @(negedge clk);
    check("rst_rden_c0", bus.rden_o, 0);
    @(negedge clk);
    check("rst_rden_c1", bus.rden_o, 0);
    check("rst_fv", bus.frame_valid_o, 0);
    check("rst_mask", bus.clause_valid_o, 0);
    check("rst_clauses", bus.clauses_o, 0);
    check("rst_count", bus.count_o, 0);
    tick();
    reset = 1'b0;

    // Full frame at full rate
    for (int k = 1; k <= 20; k++) add_clause(CW'(k));
    commit_frame();
    bus.frame_ready_i = 1'b1;
    rcount = 0;
    fv_cyc = -1;
    for (int c = 0; c < 25; c++) begin
      if (c == 20) bus.empty_i = 1'b1;
      @(negedge clk);
      if (bus.rden_o && c < 20) rcount++;
      if (bus.frame_valid_o && fv_cyc < 0) fv_cyc = c;
      tick();
    end
    check("full_rden_pulses", rcount, 20);
    check("full_fv_cycle", fv_cyc, 21);

    // Flush with nothing captured must not produce a frame
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.frame_valid_o) seen = 1'b1;
      tick();
    end
    check("empty_flush_no_frame", seen, 0);

    // Partial flush
    for (int k = 0; k < 5; k++) add_clause(CW'(9'h1A0 + k));
    commit_frame();
    fv_cyc = -1;
    for (int c = 0; c < 16; c++) begin
      bus.empty_i = (c >= 5);
      bus.flush_i = (c == 6);
      @(negedge clk);
      if (bus.frame_valid_o && fv_cyc < 0) fv_cyc = c;
      tick();
    end
    check("partial_fv_cycle", fv_cyc, 8);

    // Backpressure: hold the frame for 10 cycles with data available
    bus.frame_ready_i = 1'b0;
    for (int k = 0; k < 20; k++) add_clause(CW'(9'h100 + k));
    commit_frame();
    bus.empty_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (bus.frame_valid_o) seen = 1'b1;
      else tick();
    end
    check("bp_frame_reached", seen, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      check("bp_hold", (bus.rden_o == 1'b0) && bus.frame_valid_o &&
            (bus.clauses_o === last_data) && (bus.clause_valid_o === last_mask) &&
            (bus.count_o == 5'd20), 1);
    end
    add_clause(9'h055);
    add_clause(9'h056);
    add_clause(9'h057);
    commit_frame();
    tick();
    bus.frame_ready_i = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 4) bus.empty_i = 1'b1;
      bus.flush_i = (c == 5);
      if (c == 3) begin
        @(negedge clk);
        check("bp_restart_slot0", {bus.clause_valid_o, bus.clauses_o[CW-1:0]}, {20'h00001, 9'h055});
      end
    end
    bus.flush_i = 1'b0;

    // Gappy source with a flush landing on an in-flight read
    for (int k = 0; k < 6; k++) add_clause(CW'(9'h0A1 + k));
    commit_frame();
    reads   = 0;
    flushed = 1'b0;
    for (int c = 0; c < 40; c++) begin
      bus.flush_i = 1'b0;
      if (flushed) begin
        bus.empty_i = 1'b1;
      end else if (reads == 6) begin
        bus.empty_i = 1'b1;
        bus.flush_i = 1'b1;
        flushed     = 1'b1;
      end else begin
        bus.empty_i = (c % 2 == 1);
      end
      @(negedge clk);
      if (bus.rden_o) reads++;
      tick();
    end
    bus.flush_i = 1'b0;
    check("gappy_reads", reads, 6);

    // Idle timeout
    for (int k = 0; k < 3; k++) add_clause(CW'(9'h031 + k));
    commit_frame();
    fv_cyc = -1;
    for (int c = 0; c < 40; c++) begin
      bus.empty_i = (c >= 3);
      @(negedge clk);
      if (bus.frame_valid_o && fv_cyc < 0) fv_cyc = c;
      tick();
    end
`ifdef CLAUSE_UNPACKER_TIMEOUT_EN
    check("timeout_fv_cycle", fv_cyc, 13);
`else
    check("no_timeout_stays_fill", fv_cyc, -1);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
`endif
    for (int c = 0; c < 8; c++) tick();

    check("sb_drained", exp_data_q.size(), 0);
    check("src_drained", src_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
